// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port and the shared memory port.
// Handshake: a port raises req with addr/we/wdata stable and holds them until its ready
// pulses for exactly one cycle; rdata is meaningful only in that ready cycle.
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_rdata, i_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_rdata, i_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one fixed-latency memory port, with a starvation
// guard that lets a waiting fetch through after STARVE_MAX back-to-back data grants.
module mem_arbiter #(
   parameter int LAT        = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus,
   output logic [1:0]   dbgState
);
   localparam int CW = (LAT < 2) ? 1 : $clog2(LAT);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state, nextState;
   logic [CW-1:0] latCnt;
   logic [SW-1:0] starveCnt;
   logic          grantData, gWe;
   logic [31:0]   gAddr, gWdata, capReg;
   logic          anyReq, dataWins, lastAccess, starveFull;

   always_comb begin
      anyReq     = bus.i_req | bus.d_req;
      starveFull = (starveCnt == SW'(STARVE_MAX));
      dataWins   = bus.d_req & ~(bus.i_req & starveFull);
      lastAccess = (latCnt == CW'(LAT - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState     = state;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.i_ready   = 1'b0;
      bus.d_ready   = 1'b0;
      bus.i_rdata   = 32'h0;
      bus.d_rdata   = 32'h0;
      case (state)
         IDLE: begin
            if (anyReq) nextState = ACCESS;
         end
         ACCESS: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = gWe;
            bus.mem_addr  = gAddr & ~32'h3;
            bus.mem_wdata = gWdata;
            if (lastAccess) nextState = RESP;
         end
         RESP: begin
            bus.i_ready = ~grantData;
            bus.d_ready = grantData;
            bus.i_rdata = grantData ? 32'h0 : capReg;
            bus.d_rdata = grantData ? capReg : 32'h0;
            nextState   = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE);
      dbgState = state;
   end

   // Grant bookkeeping is only touched in IDLE, so the granted request stays frozen
   // through ACCESS and RESP regardless of what the requesters do meanwhile.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         latCnt    <= '0;
         starveCnt <= '0;
         grantData <= 1'b0;
         gWe       <= 1'b0;
         gAddr     <= 32'h0;
         gWdata    <= 32'h0;
         capReg    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               latCnt <= '0;
               if (!bus.i_req) starveCnt <= '0;
               if (anyReq) begin
                  grantData <= dataWins;
                  if (dataWins) begin
                     gAddr  <= bus.d_addr;
                     gWe    <= bus.d_we;
                     gWdata <= bus.d_wdata;
                     if (bus.i_req && !starveFull) starveCnt <= starveCnt + SW'(1);
                  end else begin
                     gAddr     <= bus.i_addr;
                     gWe       <= 1'b0;
                     gWdata    <= 32'h0;
                     starveCnt <= '0;
                  end
               end
            end
            ACCESS: begin
               latCnt <= latCnt + CW'(1);
               if (lastAccess && !gWe) capReg <= bus.mem_rdata;
            end
            default: ;
         endcase
      end
   end
endmodule
